// File: rtl/dmem_if.sv
// dmem_if: MEM-stage data-memory request/response bundle
interface dmem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        stall;
  logic        misaligned;
  modport master (output mem_read, mem_write, addr, funct3, wr_data, input rd_data, stall, misaligned);
  modport slave  (input mem_read, mem_write, addr, funct3, wr_data, output rd_data, stall, misaligned);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated byte/half/word data RAM with pipeline stall and misalignment reject
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input logic  clk,
  input logic  reset,
  dmem_if.slave bus
);
  localparam int         DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam logic [2:0] WS    = 3'(WAIT_STATES);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
  state_t                state, next;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] a_q;
  logic [2:0]            f_q;
  logic [31:0]           d_q;
  logic                  st_q;
  logic [2:0]            cnt;
  logic [31:0]           rd_q;
  logic                  req, bad, take;
  logic [3:0]            be;
  logic [31:0]           wlane, word, ext;
  logic [15:0]           sh;
  assign req  = bus.mem_read | bus.mem_write;
  assign bad  = bus.funct3[1] ? |bus.addr[1:0] : bus.funct3[0] & bus.addr[0];
  assign take = state == IDLE && req && !bad;
  assign bus.stall      = state == IDLE ? take : state != DONE;
  assign bus.misaligned = state == IDLE && req && bad && !reset;
  assign bus.rd_data    = rd_q;
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = take ? (WS != 3'd0 ? WAIT : ACCESS) : IDLE;
      WAIT:    next = cnt == 3'd1 ? ACCESS : WAIT;
      ACCESS:  next = DONE;
      default: next = IDLE;
    endcase
  end
  // funct3[1] set means word for every code, including the unlisted ones
  always_comb begin
    be    = f_q[1] ? 4'hF : f_q[0] ? (a_q[1] ? 4'hC : 4'h3) : 4'b0001 << a_q[1:0];
    wlane = f_q[1] ? d_q : f_q[0] ? {2{d_q[15:0]}} : {4{d_q[7:0]}};
    word  = mem[a_q[ADDR_WIDTH-1:2]];
    sh    = 16'(word >> {a_q[1:0], 3'b000});
    ext   = f_q[1] ? word : f_q[0] ? {{16{sh[15] & ~f_q[2]}}, sh} : {{24{sh[7] & ~f_q[2]}}, sh[7:0]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      rd_q  <= 32'd0;
    end else begin
      state <= next;
      cnt   <= take ? WS : state == WAIT ? cnt - 3'd1 : cnt;
      if (take) begin
        a_q  <= bus.addr[ADDR_WIDTH-1:0];
        f_q  <= bus.funct3;
        d_q  <= bus.wr_data;
        st_q <= bus.mem_write;
      end
      if (state == ACCESS && !st_q) rd_q <= ext;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && st_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[a_q[ADDR_WIDTH-1:2]][8*i +: 8] <= wlane[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench over three instances (WAIT_STATES 0, 1, 3)
module tb_dmem_responder;
  logic        clk = 0;
  logic        reset = 1;
  logic        rd = 0, wr = 0;
  logic [2:0]  f = 3'd0;
  logic [31:0] a = 0, d = 0;
  int          sel = 0;
  int          cyc = 0;
  int          errs = 0, total = 0;
  int          last_acc = 0;
  logic [31:0] lr [3];
  logic [31:0] sb [$];
  logic        st [3];
  logic        ms [3];
  logic [31:0] rdd [3];
  logic        stall, mis;
  logic [31:0] rd_data;
  dmem_if bi [3] ();
  for (genvar g = 0; g < 3; g++) begin : gi
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(g == 0 ? 0 : g == 1 ? 1 : 3)) u (
      .clk(clk), .reset(reset), .bus(bi[g]));
    assign bi[g].mem_read  = rd && sel == g;
    assign bi[g].mem_write = wr && sel == g;
    assign bi[g].addr      = a;
    assign bi[g].funct3    = f;
    assign bi[g].wr_data   = d;
    assign st[g]  = bi[g].stall;
    assign ms[g]  = bi[g].misaligned;
    assign rdd[g] = bi[g].rd_data;
  end
  assign stall   = st[sel];
  assign mis     = ms[sel];
  assign rd_data = rdd[sel];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic acc(input string tag, input bit r_, input bit w_, input logic [2:0] f_,
                     input logic [31:0] a_, input logic [31:0] d_, input logic [31:0] exp, input int n);
    int k;
    logic [31:0] e;
    @(posedge clk); #1;
    rd = r_; wr = w_; f = f_; a = a_; d = d_;
    last_acc = cyc;
    if (r_ && !w_) sb.push_back(exp);
    k = 0;
    @(negedge clk);
    while (stall && k <= 20) begin
      k++;
      @(negedge clk);
    end
    chk({tag, ":stall_cycles"}, k, n);
    if (r_ && !w_) begin
      e = sb.pop_front();
      chk({tag, ":rd_data"}, rd_data, e);
      lr[sel] = e;
    end else chk({tag, ":rd_hold"}, rd_data, lr[sel]);
  endtask
  task automatic bad_acc(input string tag, input bit r_, input bit w_, input logic [2:0] f_,
                         input logic [31:0] a_, input logic [31:0] d_);
    @(posedge clk); #1;
    rd = r_; wr = w_; f = f_; a = a_; d = d_;
    @(negedge clk);
    chk({tag, ":misaligned"}, mis, 1);
    chk({tag, ":stall"}, stall, 0);
    chk({tag, ":rd_hold"}, rd_data, lr[sel]);
    @(posedge clk); #1;
    rd = 0; wr = 0;
    @(negedge clk);
    chk({tag, ":pulse_end"}, mis, 0);
    chk({tag, ":idle_stall"}, stall, 0);
  endtask
  task automatic idle();
    @(posedge clk); #1;
    rd = 0; wr = 0;
    @(negedge clk);
    chk("idle:stall", stall, 0);
  endtask
  initial begin
    int c1;
    for (int i = 0; i < 3; i++) lr[i] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("reset:rd_data", rd_data, 0);
      chk("reset:stall", stall, 0);
      chk("reset:misaligned", mis, 0);
    end
    sel = 1;
    acc("sw10",   0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 3);
    acc("lw10",   1, 0, 3'b010, 32'h10,  0, 32'hDEADBEEF, 3);
    acc("sb13",   0, 1, 3'b000, 32'h13,  32'h180, 0, 3);
    acc("lb13",   1, 0, 3'b000, 32'h13,  0, 32'hFFFFFF80, 3);
    acc("lbu13",  1, 0, 3'b100, 32'h13,  0, 32'h00000080, 3);
    acc("lw10b",  1, 0, 3'b010, 32'h10,  0, 32'h80ADBEEF, 3);
    acc("lhu12",  1, 0, 3'b101, 32'h12,  0, 32'h000080AD, 3);
    acc("lh12",   1, 0, 3'b001, 32'h12,  0, 32'hFFFF80AD, 3);
    acc("sh10",   0, 1, 3'b001, 32'h10,  32'hFFFF1234, 0, 3);
    acc("lw410",  1, 0, 3'b010, 32'h410, 0, 32'h80AD1234, 3);
    acc("sw20",   0, 1, 3'b010, 32'h20,  32'h11223344, 0, 3);
    bad_acc("lh11", 1, 0, 3'b001, 32'h11, 0);
    bad_acc("sw22", 0, 1, 3'b010, 32'h22, 32'hFFFFFFFF);
    acc("lw20",   1, 0, 3'b010, 32'h20,  0, 32'h11223344, 3);
    acc("swrw30", 1, 1, 3'b010, 32'h30,  32'hA5A5A5A5, 0, 3);
    acc("lw30",   1, 0, 3'b010, 32'h30,  0, 32'hA5A5A5A5, 3);
    c1 = last_acc;
    acc("lw20b",  1, 0, 3'b010, 32'h20,  0, 32'h11223344, 3);
    chk("b2b:occupancy", last_acc - c1, 4);
    idle();
    sel = 0;
    acc("w0:sw10", 0, 1, 3'b010, 32'h10, 32'h0BADCAFE, 0, 2);
    acc("w0:lw10", 1, 0, 3'b010, 32'h10, 0, 32'h0BADCAFE, 2);
    idle();
    sel = 2;
    acc("w3:sw20", 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 5);
    acc("w3:lw20", 1, 0, 3'b010, 32'h20, 0, 32'hCAFEF00D, 5);
    idle();
    @(posedge clk); #1;
    wr = 1; f = 3'b010; a = 32'h20; d = 32'h12345678;
    @(posedge clk); #1;
    @(negedge clk);
    chk("w3:rst:stall_wait", stall, 1);
    @(posedge clk); #1;
    reset = 1; wr = 0;
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 3; i++) lr[i] = 0;
    @(negedge clk);
    chk("w3:rst:rd_data", rd_data, 0);
    chk("w3:rst:stall", stall, 0);
    acc("w3:lw20b", 1, 0, 3'b010, 32'h20, 0, 32'hCAFEF00D, 5);
    idle();
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the MEM stage of the pipelined RISC-V core, the receiving end of the `mem_read`/`mem_write` strobes that the main decoder generates. It services byte, halfword and word loads and stores against an internal word-organised RAM. It models a configurable number of wait states and holds the pipeline with `stall` until each access completes. Misaligned accesses are rejected with a one-cycle `misaligned` flag instead of being performed.

## Interface
- `ADDR_WIDTH`, default 10: byte-address bits decoded; the RAM holds 2^(ADDR_WIDTH-2) 32-bit words.
- `WAIT_STATES`, default 1: extra cycles before the RAM access; legal range 0..7.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `mem_read`  input  1  load request from EX/MEM; a level signal, held while `stall`=1.
- `mem_write`  input  1  store request from EX/MEM; a level signal, held while `stall`=1.
- `addr`  input  32  byte address; bits above ADDR_WIDTH-1 are ignored, so addresses wrap.
- `funct3`  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `wr_data`  input  32  store data; the low byte or halfword is used for SB and SH.
- `rd_data`  output  32  registered, extended load result.
- `stall`  output  1  combinational; 1 freezes PC, IF/ID, ID/EX and EX/MEM.
- `misaligned`  output  1  one-cycle pulse when a request is rejected for misalignment.

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE with no request: `stall`=0 and the FSM stays in IDLE.
- IDLE with a request (`mem_read|mem_write`) and an aligned address:
  - `stall`=1 in that same cycle.
  - addr, funct3, wr_data and the op are latched.
  - The wait counter loads WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise ACCESS.
- Alignment rules:
  - Halfword (funct3[1:0]=01) with addr[0]=1 is misaligned.
  - Word (funct3[1:0]=1x) with addr[1:0]≠0 is misaligned.
  - Byte accesses are always aligned.
- Misaligned request in IDLE:
  - `misaligned`=1 and `stall`=0 for that cycle.
  - No RAM access; `rd_data` is unchanged; the FSM stays in IDLE.
- WAIT: `stall`=1; the counter decrements each cycle; the FSM goes to ACCESS in the cycle the counter reaches 1.
- ACCESS: `stall`=1; the RAM is read or written using the latched fields.
  - Store: byte-lane write enables come from the latched addr[1:0] and size; other lanes are untouched.
  - Load: the selected byte or halfword is sign-extended (B, H) or zero-extended (BU, HU) and registered into `rd_data`.
- DONE: `stall`=0 and `rd_data` is valid; the pipeline advances this cycle. The next state is always IDLE, so a request is never re-accepted in DONE.
- `rd_data` holds the last load result until the next load completes. Stores never change `rd_data`.
- Unlisted funct3 codes (011, 110, 111) are treated as word accesses.
- `mem_read` and `mem_write` both high: treated as a store; `rd_data` is unchanged.
- Reset:
  - FSM goes to IDLE; `rd_data`=0; `misaligned`=0; the counter clears.
  - RAM contents are not cleared; they are 0 at simulation start.
- Reset mid-operation aborts the access. A store aborted before ACCESS is not performed, and a store in ACCESS completes only if `reset` is low on that edge.

## Timing
- An aligned request first seen in cycle 0 reaches DONE in cycle WAIT_STATES+2.
- `stall` is high in cycles 0..WAIT_STATES+1 and low in DONE.
- `rd_data` is valid from the DONE cycle onward.
- Back-to-back memory instructions have one IDLE sample cycle between DONE and the next acceptance. Total occupancy is WAIT_STATES+3 cycles per access.
- `misaligned` is combinational from the inputs in IDLE and lasts exactly one cycle, because the pipeline advances.
- `stall` depends only on the FSM state and the inputs in IDLE; it has no path from `rd_data`.

## Test plan
- **Word store then load, WAIT_STATES=1.** SW 0xDEADBEEF to 0x10, then LW 0x10. Required: `stall` is high for 3 cycles for each access, and `rd_data`=0xDEADBEEF in DONE.
- **Byte lanes and extension**, continuing from the memory state above:
  - SB 0x80 to 0x13 (an SB 0x180 gives the same result).
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LW 0x10 → 0x80ADBEEF.
  - LHU 0x12 → 0x000080AD.
- **Misaligned.** LH at 0x11, then SW at 0x22. Required for each: `misaligned`=1 for one cycle, `stall`=0, memory unchanged, `rd_data` unchanged; a following LW 0x20 returns the old word.
- **WAIT_STATES=0.** A single LW occupies ACCESS+DONE: `stall` is high for exactly 2 cycles, then low.
- **Reset in WAIT.** Start SW 0x12345678 to 0x20 with WAIT_STATES=3 and assert `reset` in the second WAIT cycle. Required: `rd_data`=0 and `stall`=0 after the reset edge; a subsequent LW 0x20 returns the pre-store value.
- **Simultaneous and back-to-back.** Drive `mem_read`=`mem_write`=1 with SW 0xA5A5A5A5 to 0x30. Required: memory is written and `rd_data` is unchanged. Then drive two consecutive LWs and check one IDLE cycle between DONE and the next `stall` rise.
